// File: rtl/down5bit_counter.sv
// Loadable down counter with start/stop, terminal-count pulse and optional auto-reload.
// Optional reload event counter output enabled by DOWN5BIT_COUNTER_RELOAD_CNT_EN.
//
// state | meaning
// IDLE  | stopped, out holds its value
// RUN   | counting down, reload or finish at zero
// DONE  | one-shot finished, out held at 0
module down5bit_counter #(
    parameter int                 WIDTH          = 5,
    parameter logic [WIDTH-1:0]   RELOAD_DEFAULT = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
    ,
    output logic [7:0]       reload_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt, out_nxt;
    logic             tc_nxt;
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
    logic [7:0]       cnt_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            out        <= RELOAD_DEFAULT;
            reload_reg <= RELOAD_DEFAULT;
            tc         <= 1'b0;
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
            reload_cnt <= 8'd0;
`endif
        end else begin
            state      <= state_nxt;
            out        <= out_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
            reload_cnt <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        out_nxt    = out;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
        cnt_nxt    = reload_cnt;
`endif
        if (load) begin
            out_nxt    = load_val;
            reload_nxt = load_val;
            state_nxt  = IDLE;
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
            cnt_nxt    = 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_nxt = IDLE;
                    end else if (out != '0) begin
                        out_nxt = out - WIDTH'(1);
                    end else begin
                        // zero never underflows: it always reloads or finishes
                        tc_nxt = 1'b1;
                        if (auto_reload) begin
                            out_nxt = reload_reg;
`ifdef DOWN5BIT_COUNTER_RELOAD_CNT_EN
                            if (reload_cnt != 8'hFF)
                                cnt_nxt = reload_cnt + 8'd1;
`endif
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!stop && start) begin
                        out_nxt   = reload_reg;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule
